ghost_mode_ctrl: RTL

GHOST_MODE_CTRL -- requirements
Module: ghost_mode_ctrl

---
 rtl/ghost_mode_ctrl.sv | 81 ++++++++
 1 files changed

// File: rtl/ghost_mode_ctrl.sv
// ghost_mode_ctrl: scatter/chase schedule, frightened timer and reverse pulses for the ghosts
module ghost_mode_ctrl #(
    parameter int SCAT_A        = 420,
    parameter int SCAT_B        = 300,
    parameter int CHASE_LEN     = 1200,
    parameter int FRIGHT_FRAMES = 360,
    parameter int NORMAL_SPEED  = 75,
    parameter int FRIGHT_SPEED  = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       energizer_eaten,
    output logic       isChase,
    output logic       isScatter,
    output logic       isFright,
    output logic       reverse,
    output logic [7:0] ghost_speed,
    output logic [2:0] phase
);
    logic [2:0]  r_phase, w_phase_n;
    logic [15:0] r_phase_cnt, w_phase_cnt_n;
    logic [15:0] r_fright_cnt, w_fright_cnt_n;
    logic        r_fright, w_fright_n;
    logic        r_reverse, w_rev_req;
    logic        r_chase, r_scatter;
    logic [7:0]  r_speed;
    logic [15:0] w_len;
    logic        w_ee, w_ft;
    assign w_ee  = enable & energizer_eaten;
    assign w_ft  = enable & frame_tick;
    assign w_len = r_phase[0] ? 16'(CHASE_LEN) : (r_phase[2] ? 16'(SCAT_B) : 16'(SCAT_A));
    always_comb begin
        w_phase_n      = r_phase;
        w_phase_cnt_n  = r_phase_cnt;
        w_fright_n     = r_fright;
        w_fright_cnt_n = r_fright_cnt;
        w_rev_req      = 1'b0;
        if (w_ee) begin
            w_fright_n     = 1'b1;
            w_fright_cnt_n = '0;
            w_rev_req      = 1'b1;
        end else if (w_ft && r_fright) begin
            w_fright_n     = r_fright_cnt != 16'(FRIGHT_FRAMES - 1);
            w_fright_cnt_n = w_fright_n ? r_fright_cnt + 16'd1 : '0;
        end else if (w_ft && r_phase != 3'd7) begin
            w_rev_req     = r_phase_cnt == w_len - 16'd1;
            w_phase_n     = w_rev_req ? r_phase + 3'd1 : r_phase;
            w_phase_cnt_n = w_rev_req ? '0 : r_phase_cnt + 16'd1;
        end
    end
    // a request landing right after a pulse is absorbed so reverse never stretches to two clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase      <= '0;
            r_phase_cnt  <= '0;
            r_fright_cnt <= '0;
            r_fright     <= 1'b0;
            r_reverse    <= 1'b0;
            r_chase      <= 1'b0;
            r_scatter    <= 1'b1;
            r_speed      <= 8'(NORMAL_SPEED);
        end else begin
            r_phase      <= w_phase_n;
            r_phase_cnt  <= w_phase_cnt_n;
            r_fright_cnt <= w_fright_cnt_n;
            r_fright     <= w_fright_n;
            r_reverse    <= w_rev_req & ~r_reverse;
            r_chase      <= w_phase_n[0];
            r_scatter    <= ~w_phase_n[0];
            r_speed      <= w_fright_n ? 8'(FRIGHT_SPEED) : 8'(NORMAL_SPEED);
        end
    end
    assign isChase     = r_chase;
    assign isScatter   = r_scatter;
    assign isFright    = r_fright;
    assign reverse     = r_reverse;
    assign ghost_speed = r_speed;
    assign phase       = r_phase;
endmodule
